// File: rtl/ofs_plat_local_mem_avalon_burst_splitter.sv
// Splits AFU Avalon-MM bursts into FIU-sized sub-bursts and squashes the write responses of non-final sub-bursts.
// Optional macro OFS_PLAT_LM_BURST_SPLIT_ALIGN_EN: sub-bursts after the first start FIU_MAX-aligned.
module ofs_plat_local_mem_avalon_burst_splitter #(
   parameter int ADDR_WIDTH      = 27,
   parameter int DATA_WIDTH      = 512,
   parameter int AFU_BURST_WIDTH = 7,
   parameter int FIU_BURST_WIDTH = 3,
   parameter int USER_WIDTH      = 4
) (
   input  logic                       clk,
   input  logic                       reset,

   input  logic [ADDR_WIDTH-1:0]      afu_address,
   input  logic [AFU_BURST_WIDTH-1:0] afu_burstcount,
   input  logic                       afu_read,
   input  logic                       afu_write,
   input  logic [DATA_WIDTH-1:0]      afu_writedata,
   input  logic [DATA_WIDTH/8-1:0]    afu_byteenable,
   input  logic [USER_WIDTH-1:0]      afu_user,
   output logic                       afu_waitrequest,
   output logic [DATA_WIDTH-1:0]      afu_readdata,
   output logic                       afu_readdatavalid,
   output logic [USER_WIDTH-1:0]      afu_readresponseuser,
   output logic                       afu_writeresponsevalid,
   output logic [USER_WIDTH-1:0]      afu_writeresponseuser,

   output logic [ADDR_WIDTH-1:0]      fiu_address,
   output logic [FIU_BURST_WIDTH-1:0] fiu_burstcount,
   output logic                       fiu_read,
   output logic                       fiu_write,
   output logic [DATA_WIDTH-1:0]      fiu_writedata,
   output logic [DATA_WIDTH/8-1:0]    fiu_byteenable,
   output logic [USER_WIDTH-1:0]      fiu_user,
   input  logic                       fiu_waitrequest,
   input  logic [DATA_WIDTH-1:0]      fiu_readdata,
   input  logic                       fiu_readdatavalid,
   input  logic [USER_WIDTH-1:0]      fiu_readresponseuser,
   input  logic                       fiu_writeresponsevalid,
   input  logic [USER_WIDTH-1:0]      fiu_writeresponseuser
);

   localparam int LM_AVALON_UFLAG_NO_REPLY = 0;
   localparam logic [AFU_BURST_WIDTH-1:0] FIU_MAX = AFU_BURST_WIDTH'(1 << (FIU_BURST_WIDTH-1));

   typedef enum logic [1:0] {IDLE, RD_SPLIT, WR_BURST} state_t;

   state_t                       state_q, state_d;
   logic                         rdy_q;
   logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
   logic [AFU_BURST_WIDTH-1:0]   rem_q, rem_d;
   logic [FIU_BURST_WIDTH-1:0]   sub_left_q, sub_left_d;
   logic [USER_WIDTH-1:0]        user_q, user_d;

   logic                         rd_q, rd_d, wr_q, wr_d;
   logic [ADDR_WIDTH-1:0]        oaddr_q, oaddr_d;
   logic [FIU_BURST_WIDTH-1:0]   obc_q, obc_d;
   logic [DATA_WIDTH-1:0]        odata_q, odata_d;
   logic [DATA_WIDTH/8-1:0]      obe_q, obe_d;
   logic [USER_WIDTH-1:0]        ouser_q, ouser_d;

   logic                         out_busy, load_ok, rd_acc, wr_acc;
   logic [AFU_BURST_WIDTH-1:0]   room_afu, room_q, sl_afu, sl_q;
   logic [FIU_BURST_WIDTH-1:0]   sl_afu_f, sl_q_f;

   function automatic logic [AFU_BURST_WIDTH-1:0] clamp_len(
      input logic [AFU_BURST_WIDTH-1:0] r,
      input logic [AFU_BURST_WIDTH-1:0] lim);
      return (r < lim) ? r : lim;
   endfunction

   function automatic logic [USER_WIDTH-1:0] tag_no_reply(
      input logic [USER_WIDTH-1:0] u,
      input logic                  en);
      logic [USER_WIDTH-1:0] t;
      t = u;
      t[LM_AVALON_UFLAG_NO_REPLY] = u[LM_AVALON_UFLAG_NO_REPLY] | en;
      return t;
   endfunction

`ifdef OFS_PLAT_LM_BURST_SPLIT_ALIGN_EN
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << (FIU_BURST_WIDTH-1)) - 1);
   // Room left before the next FIU_MAX boundary.
   assign room_afu = FIU_MAX - AFU_BURST_WIDTH'(afu_address & ALIGN_MASK);
   assign room_q   = FIU_MAX - AFU_BURST_WIDTH'(addr_q & ALIGN_MASK);
`else
   assign room_afu = FIU_MAX;
   assign room_q   = FIU_MAX;
`endif

   assign sl_afu   = clamp_len(afu_burstcount, room_afu);
   assign sl_q     = clamp_len(rem_q, room_q);
   assign sl_afu_f = sl_afu[FIU_BURST_WIDTH-1:0];
   assign sl_q_f   = sl_q[FIU_BURST_WIDTH-1:0];

   assign out_busy        = (rd_q | wr_q) & fiu_waitrequest;
   assign load_ok         = ~out_busy;
   assign afu_waitrequest = ~rdy_q | out_busy | (state_q == RD_SPLIT);
   assign rd_acc          = afu_read & ~afu_waitrequest;
   assign wr_acc          = afu_write & ~afu_waitrequest;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      sub_left_d = sub_left_q;
      user_d     = user_q;
      rd_d       = rd_q & fiu_waitrequest;
      wr_d       = wr_q & fiu_waitrequest;
      oaddr_d    = oaddr_q;
      obc_d      = obc_q;
      odata_d    = odata_q;
      obe_d      = obe_q;
      ouser_d    = ouser_q;

      unique case (state_q)
         IDLE: begin
            if (rd_acc) begin
               rd_d    = 1'b1;
               oaddr_d = afu_address;
               obc_d   = sl_afu_f;
               ouser_d = afu_user;
               if (afu_burstcount > sl_afu) begin
                  state_d = RD_SPLIT;
                  addr_d  = afu_address + ADDR_WIDTH'(sl_afu);
                  rem_d   = afu_burstcount - sl_afu;
                  user_d  = afu_user;
               end
            end else if (wr_acc) begin
               wr_d    = 1'b1;
               oaddr_d = afu_address;
               obc_d   = sl_afu_f;
               odata_d = afu_writedata;
               obe_d   = afu_byteenable;
               ouser_d = tag_no_reply(afu_user, afu_burstcount > sl_afu);
               if (afu_burstcount != AFU_BURST_WIDTH'(1)) begin
                  state_d    = WR_BURST;
                  addr_d     = afu_address + ADDR_WIDTH'(sl_afu);
                  rem_d      = afu_burstcount - AFU_BURST_WIDTH'(1);
                  sub_left_d = sl_afu_f - FIU_BURST_WIDTH'(1);
                  user_d     = afu_user;
               end
            end
         end
         RD_SPLIT: begin
            if (load_ok) begin
               rd_d    = 1'b1;
               oaddr_d = addr_q;
               obc_d   = sl_q_f;
               ouser_d = user_q;
               addr_d  = addr_q + ADDR_WIDTH'(sl_q);
               rem_d   = rem_q - sl_q;
               if (rem_q == sl_q) state_d = IDLE;
            end
         end
         WR_BURST: begin
            if (wr_acc) begin
               wr_d    = 1'b1;
               odata_d = afu_writedata;
               obe_d   = afu_byteenable;
               rem_d   = rem_q - AFU_BURST_WIDTH'(1);
               // A drained sub-burst counter means this beat opens the next sub-burst.
               if (sub_left_q == '0) begin
                  oaddr_d    = addr_q;
                  obc_d      = sl_q_f;
                  ouser_d    = tag_no_reply(user_q, rem_q > sl_q);
                  sub_left_d = sl_q_f - FIU_BURST_WIDTH'(1);
                  addr_d     = addr_q + ADDR_WIDTH'(sl_q);
               end else begin
                  sub_left_d = sub_left_q - FIU_BURST_WIDTH'(1);
               end
               if (rem_q == AFU_BURST_WIDTH'(1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rdy_q      <= 1'b0;
         rem_q      <= '0;
         sub_left_q <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         rdy_q      <= 1'b1;
         rem_q      <= rem_d;
         sub_left_q <= sub_left_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      user_q  <= user_d;
      oaddr_q <= oaddr_d;
      obc_q   <= obc_d;
      odata_q <= odata_d;
      obe_q   <= obe_d;
      ouser_q <= ouser_d;
   end

   assign fiu_read       = rd_q;
   assign fiu_write      = wr_q;
   assign fiu_address    = oaddr_q;
   assign fiu_burstcount = obc_q;
   assign fiu_writedata  = odata_q;
   assign fiu_byteenable = obe_q;
   assign fiu_user       = ouser_q;

   // Responses are zero-latency pass-through; only NO_REPLY write responses are dropped.
   assign afu_readdata           = fiu_readdata;
   assign afu_readdatavalid      = fiu_readdatavalid & ~reset;
   assign afu_readresponseuser   = fiu_readresponseuser;
   assign afu_writeresponsevalid = fiu_writeresponsevalid & ~fiu_writeresponseuser[LM_AVALON_UFLAG_NO_REPLY] & ~reset;
   assign afu_writeresponseuser  = fiu_writeresponseuser;

endmodule

// File: doc/ofs_plat_local_mem_avalon_burst_splitter.md
Name: ofs_plat_local_mem_avalon_burst_splitter

Overview:
- Splits AFU-sized Avalon-MM local-memory bursts into FIU-sized bursts, in order.
- Tags every non-final write sub-burst with user flag LM_AVALON_UFLAG_NO_REPLY and squashes the matching write responses, so the AFU sees one response per original burst.
- Sits between the AFU-facing local_mem Avalon interface and the FIU memory port.
- Successor to the fixed single-flag scheme: burst widths and user width are parametrised, with an optional alignment mode.

Parameters:
- ADDR_WIDTH, 27, line (word) address width.
- DATA_WIDTH, 512, data bus width; byteenable is DATA_WIDTH/8.
- AFU_BURST_WIDTH, 7, AFU burstcount width; max AFU burst = 2^(AFU_BURST_WIDTH-1).
- FIU_BURST_WIDTH, 3, FIU burstcount width; FIU_MAX = 2^(FIU_BURST_WIDTH-1). Must be <= AFU_BURST_WIDTH.
- USER_WIDTH, 4, user field width. Must be >= LM_AVALON_UFLAG_WIDTH. Bit LM_AVALON_UFLAG_NO_REPLY is reserved.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- afu_address  in  ADDR_WIDTH  burst start line address, sampled on the first beat.
- afu_burstcount  in  AFU_BURST_WIDTH  beats, 1..max.
- afu_read / afu_write  in  1  request strobes; never both high.
- afu_writedata  in  DATA_WIDTH  write beat.
- afu_byteenable  in  DATA_WIDTH/8  write beat byte mask.
- afu_user  in  USER_WIDTH  request user bits.
- afu_waitrequest  out  1  backpressure to the AFU.
- afu_readdata / afu_readdatavalid / afu_readresponseuser  out  DATA_WIDTH/1/USER_WIDTH  read return.
- afu_writeresponsevalid / afu_writeresponseuser  out  1/USER_WIDTH  write response.
- fiu_address, fiu_burstcount (FIU_BURST_WIDTH), fiu_read, fiu_write, fiu_writedata, fiu_byteenable, fiu_user  out  FIU request.
- fiu_waitrequest  in  1  FIU backpressure.
- fiu_readdata, fiu_readdatavalid, fiu_readresponseuser, fiu_writeresponsevalid, fiu_writeresponseuser  in  FIU responses.

Behaviour:
- Reset values:
  - fiu_read, fiu_write, afu_readdatavalid, afu_writeresponsevalid = 0.
  - afu_waitrequest = 1 during reset; it drops the cycle after reset deasserts.
  - All counters and FSM state are cleared.
- Request path is a one-entry registered output stage (fiu_* are flop outputs); latency is 1 cycle from AFU acceptance to FIU presentation.
- Acceptance rules:
  - A beat is accepted when the AFU strobe is high and afu_waitrequest = 0.
  - An FIU beat completes when its strobe is high and fiu_waitrequest = 0.
  - The output register loads when it is empty or completing in the same cycle.
- FSM states:
  - IDLE → RD_SPLIT: read accepted with afu_burstcount > sub-burst length (sublen). Otherwise a single FIU read is issued and the FSM stays in IDLE.
  - RD_SPLIT: issues successive reads at addr += sublen, remaining -= sublen. afu_waitrequest = 1 throughout. Returns to IDLE when the last sub-burst completes.
  - IDLE → WR_BURST: first write beat accepted. Latch address and remaining beats, and start the first sub-burst.
  - WR_BURST: each beat is forwarded.
    - The first beat of each sub-burst carries fiu_address and fiu_burstcount = sublen.
    - Later beats of a sub-burst pass data and byteenable only.
    - Returns to IDLE after the final AFU beat is accepted into the output register.
  - A single-beat write completes in IDLE without entering WR_BURST.
- Sub-burst length: sublen = min(remaining, FIU_MAX).
- User bits:
  - Non-final write sub-bursts: fiu_user = afu_user with NO_REPLY forced to 1.
  - Final write sub-burst: fiu_user = afu_user unchanged, so an AFU-set NO_REPLY propagates.
  - All read sub-bursts carry afu_user unchanged.
- Responses (combinational pass-through, zero latency):
  - Read data, readdatavalid and user pass through unmodified; beat count is naturally preserved.
  - afu_writeresponsevalid = fiu_writeresponsevalid & ~fiu_writeresponseuser[NO_REPLY]; user passes through.
- Arithmetic:
  - The address adder wraps modulo 2^ADDR_WIDTH with no error.
  - A burstcount equal to the maximum (MSB set, e.g. 64 for width 7) is a legal value.
- Simultaneous events: the last beat of a write burst and a new read may not overlap. The new request waits one cycle, since afu_waitrequest is held while the output register is full and stalled.
- Reset mid-burst: all state is discarded immediately. No partial sub-burst is completed, and the responses that follow are undefined to the AFU.

Optional Feature:
- Macro: OFS_PLAT_LM_BURST_SPLIT_ALIGN_EN.
- Defined: sublen = min(remaining, FIU_MAX - (addr mod FIU_MAX)). Every sub-burst after the first starts FIU_MAX-aligned, and a short aligned burst may still split.
- Undefined: sublen = min(remaining, FIU_MAX), with no alignment logic.

Test Plan:
- Read burst 10 @0x100, FIU_MAX=4 → FIU reads (0x100,4), (0x104,4), (0x108,2); 10 readdatavalid beats to AFU; afu_waitrequest high until the third read completes.
- Write burst 6 @0x200, user=0 → (0x200,4, NO_REPLY=1), then (0x204,2, user=0); FIU returns 2 responses; exactly 1 afu_writeresponsevalid.
- Write burst 1 @0x10, afu_user NO_REPLY=1 → single FIU write with user passed; its response is squashed; zero AFU responses.
- Random fiu_waitrequest (50%) during a 64-beat write → 16 sub-bursts of 4; data and byteenable order preserved beat-for-beat; no beats lost or duplicated.
- With ALIGN_EN: read @0x102, burst 6 → (0x102,2), (0x104,4). Without it: (0x102,4), (0x106,2).
- Assert reset at beat 3 of an 8-beat write → fiu_write=0 next cycle; afu_waitrequest=1 during reset; a new read after reset issues cleanly in IDLE.
